// File: rtl/uart_seq_if.sv
// uart_seq_if
//   CPU-side byte handshakes of the um245r sequencer.
//   master : the CPU / bus controller (offers TX bytes, consumes RX bytes)
//   slave  : uart_seq
//   Signals:
//     tx_valid  CPU offers a TX byte
//     tx_data   TX byte
//     tx_ready  TX holding register is empty
//     rx_valid  RX holding register is full
//     rx_data   RX byte
//     rx_ready  CPU consumes the RX byte
interface uart_seq_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output tx_valid, tx_data, rx_ready,
                    input  tx_ready, rx_valid, rx_data);
    modport slave  (input  tx_valid, tx_data, rx_ready,
                    output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/uart_seq.sv
// uart_seq
//   Sequences an um245r-style FIFO UART for the CPU. Owns the WR / _RD
//   strobes and the data-bus output enable, buffers one TX and one RX byte
//   behind valid/ready handshakes, and arbitrates round-robin between a
//   pending TX write and an RX read.
//
//   Optional feature: define UART_SEQ_TIMEOUT_EN to discard a TX byte that
//   has waited TIMEOUT_CYCLES for TX FIFO space and raise sticky tx_timeout.
//   Without the macro a TX byte waits indefinitely and tx_timeout is 0.
//
//   Ports:
//     clk         system clock, rising edge
//     _mr         synchronous active-low reset
//     cpu         CPU handshakes (uart_seq_if.slave)
//     uart_d_out  data driven to the UART
//     _uart_d_oe  active-low enable of the TX buffer onto the UART bus
//     uart_d_in   data from the UART
//     uart_wr     UART WR, the UART writes on its falling edge
//     _uart_rd    UART _RD, active-low
//     _txe        UART TX FIFO has space when low (asynchronous)
//     _rxf        UART RX data available when low (asynchronous)
//     busy        sequencer is not IDLE
//     tx_timeout  sticky TX timeout flag
module uart_seq #(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       _mr,
    uart_seq_if.slave  cpu,
    output logic [7:0] uart_d_out,
    output logic       _uart_d_oe,
    input  logic [7:0] uart_d_in,
    output logic       uart_wr,
    output logic       _uart_rd,
    input  logic       _txe,
    input  logic       _rxf,
    output logic       busy,
    output logic       tx_timeout
);
    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_B = (RECOVER_CYCLES > TIMEOUT_CYCLES) ? RECOVER_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {IDLE, TX_SETUP, TX_HOLD, RX_STROBE, RECOVER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    tx_hold;
    logic [7:0]    rx_q;
    logic          tx_full;
    logic          rx_full;
    logic          rr_rx;      // 1: RX wins the next tie
    logic          txe_meta;
    logic          rxf_meta;
    logic          _txe_s;
    logic          _rxf_s;
    logic          tx_elig;
    logic          rx_elig;
    logic          grant_rx;
    logic          grant_tx;

`ifdef UART_SEQ_TIMEOUT_EN
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;
    assign tx_timeout = timeout_q;
`else
    assign tx_timeout = 1'b0;
`endif

    assign tx_elig  = tx_full && !_txe_s;
    assign rx_elig  = !rx_full && !_rxf_s;
    assign grant_rx = rx_elig && (!tx_elig || rr_rx);
    assign grant_tx = tx_elig && !grant_rx;

    assign cpu.tx_ready = !tx_full;
    assign cpu.rx_valid = rx_full;
    assign cpu.rx_data  = rx_q;
    assign busy         = (state != IDLE);

    // Single FSM block; every strobe is a flop set on entry to its state, so
    // WR and _RD can never be active together and never glitch.
    always_ff @(posedge clk) begin
        if (!_mr) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_hold    <= '0;
            rx_q       <= '0;
            tx_full    <= 1'b0;
            rx_full    <= 1'b0;
            rr_rx      <= 1'b1;
            txe_meta   <= 1'b1;
            rxf_meta   <= 1'b1;
            _txe_s     <= 1'b1;
            _rxf_s     <= 1'b1;
            uart_wr    <= 1'b0;
            _uart_rd   <= 1'b1;
            _uart_d_oe <= 1'b1;
            uart_d_out <= '0;
`ifdef UART_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            txe_meta <= _txe;
            _txe_s   <= txe_meta;
            rxf_meta <= _rxf;
            _rxf_s   <= rxf_meta;

            if (cpu.tx_valid && !tx_full) begin
                tx_hold <= cpu.tx_data;
                tx_full <= 1'b1;
            end
            if (rx_full && cpu.rx_ready)
                rx_full <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_rx) begin
                        rr_rx    <= 1'b0;
                        cnt      <= CW'(STROBE_CYCLES - 1);
                        _uart_rd <= 1'b0;
                        state    <= RX_STROBE;
                    end else if (grant_tx) begin
                        rr_rx      <= 1'b1;
                        cnt        <= CW'(SETUP_CYCLES - 1);
                        uart_wr    <= 1'b1;
                        _uart_d_oe <= 1'b0;
                        uart_d_out <= tx_hold;
                        state      <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    if (cnt == '0) begin
                        uart_wr <= 1'b0;   // falling edge: UART latches data
                        state   <= TX_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                TX_HOLD: begin
                    // data held one more cycle past the WR fall for hold time
                    _uart_d_oe <= 1'b1;
                    tx_full    <= 1'b0;
                    cnt        <= CW'(RECOVER_CYCLES - 1);
                    state      <= RECOVER;
                end
                RX_STROBE: begin
                    if (cnt == '0) begin
                        rx_q     <= uart_d_in;
                        rx_full  <= 1'b1;
                        _uart_rd <= 1'b1;
                        cnt      <= CW'(RECOVER_CYCLES - 1);
                        state    <= RECOVER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase

`ifdef UART_SEQ_TIMEOUT_EN
            // Only counts while the byte sits un-granted; a write already
            // on the bus is never torn down by the timeout.
            if (state == IDLE && grant_tx) begin
                wait_cnt <= '0;
            end else if (tx_full && _txe_s && state != TX_SETUP && state != TX_HOLD) begin
                if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    tx_full   <= 1'b0;
                    timeout_q <= 1'b1;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_uart_seq.sv
// tb_uart_seq
//   Directed self-checking bench for uart_seq (default parameters).
//   Inputs are driven on the falling edge and outputs sampled there too.
module tb_uart_seq;
    logic       clk = 1'b0;
    logic       _mr = 1'b0;
    logic [7:0] uart_d_out;
    logic [7:0] uart_d_in = 8'h00;
    logic       _uart_d_oe;
    logic       uart_wr;
    logic       _uart_rd;
    logic       _txe = 1'b1;
    logic       _rxf = 1'b1;
    logic       busy;
    logic       tx_timeout;
    int         n_cmp = 0;
    int         n_err = 0;

    uart_seq_if cpu();

    uart_seq dut (
        .clk        (clk),
        ._mr        (_mr),
        .cpu        (cpu),
        .uart_d_out (uart_d_out),
        ._uart_d_oe (_uart_d_oe),
        .uart_d_in  (uart_d_in),
        .uart_wr    (uart_wr),
        ._uart_rd   (_uart_rd),
        ._txe       (_txe),
        ._rxf       (_rxf),
        .busy       (busy),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        _mr = 1'b0; cpu.tx_valid = 1'b1; cpu.tx_data = 8'hFF; cpu.rx_ready = 1'b1;
        _txe = 1'b0; _rxf = 1'b0; uart_d_in = 8'hFF;
        tick(3);
        n_cmp++; if (uart_wr !== 1'b0)      begin n_err++; $display("FAIL reset_wr got %b want 0", uart_wr); end
        n_cmp++; if (_uart_rd !== 1'b1)     begin n_err++; $display("FAIL reset_rd got %b want 1", _uart_rd); end
        n_cmp++; if (_uart_d_oe !== 1'b1)   begin n_err++; $display("FAIL reset_oe got %b want 1", _uart_d_oe); end
        n_cmp++; if (cpu.tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready got %b want 1", cpu.tx_ready); end
        n_cmp++; if (cpu.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got %b want 0", cpu.rx_valid); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (uart_d_out !== 8'h00)  begin n_err++; $display("FAIL reset_dout got %h want 00", uart_d_out); end
        n_cmp++; if (cpu.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got %h want 00", cpu.rx_data); end
        n_cmp++; if (tx_timeout !== 1'b0)   begin n_err++; $display("FAIL reset_timeout got %b want 0", tx_timeout); end
        cpu.tx_valid = 1'b0; cpu.rx_ready = 1'b0; _txe = 1'b1; _rxf = 1'b1;
        tick(1);
        _mr = 1'b1;
        tick(3);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_tx;
        logic [5:0] wr_v, oe_v, rdy_v, bsy_v, rd_v;
        int dd;
        wr_v = '0; oe_v = '0; rdy_v = '0; bsy_v = '0; rd_v = '0; dd = 0;
        _txe = 1'b0;
        tick(3);
        cpu.tx_data = 8'h5A; cpu.tx_valid = 1'b1;
        tick(1);
        cpu.tx_valid = 1'b0;
        n_cmp++; if (cpu.tx_ready !== 1'b0) begin n_err++; $display("FAIL tx_accept_ready got %b want 0", cpu.tx_ready); end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            wr_v  = {wr_v[4:0], uart_wr};
            oe_v  = {oe_v[4:0], _uart_d_oe};
            rdy_v = {rdy_v[4:0], cpu.tx_ready};
            bsy_v = {bsy_v[4:0], busy};
            rd_v  = {rd_v[4:0], _uart_rd};
            if (!_uart_d_oe && uart_d_out == 8'h5A) dd++;
        end
        n_cmp++; if (wr_v !== 6'b110000)  begin n_err++; $display("FAIL tx_wr_seq got %b want 110000", wr_v); end
        n_cmp++; if (oe_v !== 6'b000111)  begin n_err++; $display("FAIL tx_oe_seq got %b want 000111", oe_v); end
        n_cmp++; if (rdy_v !== 6'b000111) begin n_err++; $display("FAIL tx_ready_seq got %b want 000111", rdy_v); end
        n_cmp++; if (bsy_v !== 6'b111100) begin n_err++; $display("FAIL tx_busy_seq got %b want 111100", bsy_v); end
        n_cmp++; if (rd_v !== 6'b111111)  begin n_err++; $display("FAIL tx_rd_quiet got %b want 111111", rd_v); end
        n_cmp++; if (dd !== 3)            begin n_err++; $display("FAIL tx_data_driven got %0d want 3", dd); end
        _txe = 1'b1;
        tick(3);
    endtask

    task automatic test_single_rx;
        logic [9:0] rd_v;
        rd_v = '0;
        _rxf = 1'b0; uart_d_in = 8'hC3;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            rd_v = {rd_v[8:0], _uart_rd};
        end
        n_cmp++; if (rd_v !== 10'b1100111111) begin n_err++; $display("FAIL rx_rd_seq got %b want 1100111111", rd_v); end
        n_cmp++; if (cpu.rx_valid !== 1'b1)   begin n_err++; $display("FAIL rx_valid got %b want 1", cpu.rx_valid); end
        n_cmp++; if (cpu.rx_data !== 8'hC3)   begin n_err++; $display("FAIL rx_data got %h want c3", cpu.rx_data); end
        uart_d_in = 8'h77; cpu.rx_ready = 1'b1;
        tick(1);
        cpu.rx_ready = 1'b0; _rxf = 1'b1;
        n_cmp++; if (cpu.rx_valid !== 1'b0) begin n_err++; $display("FAIL rx_consume got %b want 0", cpu.rx_valid); end
        tick(8);
        n_cmp++; if (cpu.rx_valid !== 1'b1) begin n_err++; $display("FAIL rx2_valid got %b want 1", cpu.rx_valid); end
        n_cmp++; if (cpu.rx_data !== 8'h77) begin n_err++; $display("FAIL rx2_data got %h want 77", cpu.rx_data); end
        cpu.rx_ready = 1'b1;
        tick(1);
        cpu.rx_ready = 1'b0;
        tick(3);
        n_cmp++; if (cpu.rx_valid !== 1'b0) begin n_err++; $display("FAIL rx2_drained got %b want 0", cpu.rx_valid); end
    endtask

    task automatic test_contention;
        logic       ev [32];
        int         nev, n_t, overlap, tx_sent;
        logic       prev_rd, prev_wr, got_rx;
        logic [7:0] first_rx, first_tx;
        logic [3:0] order;
        nev = 0; n_t = 0; overlap = 0; tx_sent = 1;
        prev_rd = 1'b1; prev_wr = 1'b0; got_rx = 1'b0;
        first_rx = 8'h00; first_tx = 8'h00;
        _mr = 1'b0;
        tick(1);
        _mr = 1'b1; _txe = 1'b0; _rxf = 1'b0; uart_d_in = 8'hA1;
        cpu.tx_data = 8'h81; cpu.tx_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick(1);
            if (prev_rd && !_uart_rd && nev < 32) begin ev[nev] = 1'b1; nev++; end
            if (!prev_wr && uart_wr && nev < 32) begin
                ev[nev] = 1'b0; nev++;
                if (n_t == 0) first_tx = uart_d_out;
                n_t++;
            end
            if (uart_wr && !_uart_rd) overlap++;
            prev_rd = _uart_rd; prev_wr = uart_wr;
            if (cpu.rx_valid && !got_rx) begin first_rx = cpu.rx_data; got_rx = 1'b1; end
            cpu.rx_ready = cpu.rx_valid;
            cpu.tx_valid = cpu.tx_ready && (tx_sent < 2);
            if (cpu.tx_valid) begin cpu.tx_data = 8'h82; tx_sent++; end
            if (i == 30) _rxf = 1'b1;
        end
        cpu.rx_ready = 1'b0; cpu.tx_valid = 1'b0; _txe = 1'b1;
        tick(3);
        order = (nev >= 4) ? {ev[0], ev[1], ev[2], ev[3]} : 4'b0000;
        n_cmp++; if (order !== 4'b1010)   begin n_err++; $display("FAIL arb_order got %b want 1010 (1=RX)", order); end
        n_cmp++; if (overlap !== 0)       begin n_err++; $display("FAIL arb_overlap got %0d want 0", overlap); end
        n_cmp++; if (n_t !== 2)           begin n_err++; $display("FAIL arb_tx_count got %0d want 2", n_t); end
        n_cmp++; if (first_tx !== 8'h81)  begin n_err++; $display("FAIL arb_tx_data got %h want 81", first_tx); end
        n_cmp++; if (first_rx !== 8'hA1)  begin n_err++; $display("FAIL arb_rx_data got %h want a1", first_rx); end
        n_cmp++; if (cpu.rx_valid !== 1'b0) begin n_err++; $display("FAIL arb_rx_drained got %b want 0", cpu.rx_valid); end
    endtask

    task automatic test_tx_flow;
        int wr_hi, seen;
        wr_hi = 0; seen = 0;
        tick(3);
        cpu.tx_data = 8'h11; cpu.tx_valid = 1'b1;
        tick(1);
        cpu.tx_valid = 1'b0;
        for (int k = 2; k <= 300; k++) begin
            tick(1);
            if (uart_wr) wr_hi++;
`ifdef UART_SEQ_TIMEOUT_EN
            if (k == 255) begin
                n_cmp++; if (cpu.tx_ready !== 1'b0) begin n_err++; $display("FAIL to_before got %b want 0", cpu.tx_ready); end
            end
            if (k == 256) begin
                n_cmp++; if (cpu.tx_ready !== 1'b1) begin n_err++; $display("FAIL to_after got %b want 1", cpu.tx_ready); end
            end
`endif
        end
        n_cmp++; if (wr_hi !== 0) begin n_err++; $display("FAIL flow_no_wr got %0d want 0", wr_hi); end
`ifdef UART_SEQ_TIMEOUT_EN
        n_cmp++; if (tx_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag got %b want 1", tx_timeout); end
        _txe = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (uart_wr) seen++;
        end
        n_cmp++; if (seen !== 0)          begin n_err++; $display("FAIL to_discard got %0d want 0", seen); end
        n_cmp++; if (tx_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", tx_timeout); end
`else
        n_cmp++; if (cpu.tx_ready !== 1'b0) begin n_err++; $display("FAIL flow_pending got %b want 0", cpu.tx_ready); end
        n_cmp++; if (tx_timeout !== 1'b0)   begin n_err++; $display("FAIL flow_timeout got %b want 0", tx_timeout); end
        _txe = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (uart_wr && uart_d_out == 8'h11) seen++;
        end
        n_cmp++; if (seen !== 2)            begin n_err++; $display("FAIL flow_written got %0d want 2", seen); end
        n_cmp++; if (cpu.tx_ready !== 1'b1) begin n_err++; $display("FAIL flow_done got %b want 1", cpu.tx_ready); end
`endif
    endtask

    task automatic test_mid_reset;
        int wr_hi;
        wr_hi = 0;
        _txe = 1'b0;
        tick(3);
        cpu.tx_data = 8'h3C; cpu.tx_valid = 1'b1;
        tick(1);
        cpu.tx_valid = 1'b0;
        tick(1);
        n_cmp++; if (uart_wr !== 1'b1)    begin n_err++; $display("FAIL mr_setup_wr got %b want 1", uart_wr); end
        n_cmp++; if (_uart_d_oe !== 1'b0) begin n_err++; $display("FAIL mr_setup_oe got %b want 0", _uart_d_oe); end
        _mr = 1'b0;
        tick(1);
        n_cmp++; if (uart_wr !== 1'b0)      begin n_err++; $display("FAIL mr_wr got %b want 0", uart_wr); end
        n_cmp++; if (_uart_d_oe !== 1'b1)   begin n_err++; $display("FAIL mr_oe got %b want 1", _uart_d_oe); end
        n_cmp++; if (cpu.tx_ready !== 1'b1) begin n_err++; $display("FAIL mr_tx_full got ready=%b want 1", cpu.tx_ready); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL mr_busy got %b want 0", busy); end
        _mr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (uart_wr) wr_hi++;
        end
        n_cmp++; if (wr_hi !== 0) begin n_err++; $display("FAIL mr_no_rewrite got %0d want 0", wr_hi); end
    endtask

    initial begin
        cpu.tx_valid = 1'b0; cpu.tx_data = 8'h00; cpu.rx_ready = 1'b0;
        test_reset();
        test_single_tx();
        test_single_rx();
        test_contention();
        test_tx_flow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
